ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 196 +++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Turns a stream of PS/2 set-2 bytes into key events
//               {ext, brk, code, ascii}, tracks the shift keys, and queues
//               the events in a 4-entry show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] ev_ascii,
    output logic       shift,
    output logic       ovf
);

    localparam logic [7:0] C_PFX_EXT   = 8'hE0;
    localparam logic [7:0] C_PFX_BRK   = 8'hF0;
    localparam logic [7:0] C_LSHIFT    = 8'h12;
    localparam logic [7:0] C_RSHIFT    = 8'h59;
    localparam logic [7:0] C_ENTER     = 8'h5A;
    localparam logic [2:0] C_FIFO_FULL = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_shift_l;
    logic        r_shift_r;
    logic        r_ovf;
    logic [17:0] r_mem [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;

    logic        w_is_pfx;
    logic        w_is_noise;
    logic        w_complete;
    logic        w_ext;
    logic        w_brk;
    logic [7:0]  w_ascii;
    logic [17:0] w_entry;
    logic [17:0] w_head;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_empty;

    // Make-code to ASCII for non-extended keys; letters follow shift.
    function automatic logic [7:0] f_make_ascii(input logic [7:0] code,
                                                input logic       sh);
        logic [7:0] letter;
        logic [7:0] result;
        letter = 8'h00;
        result = 8'h00;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h45: result = "0";  8'h16: result = "1";  8'h1E: result = "2";
            8'h26: result = "3";  8'h25: result = "4";  8'h2E: result = "5";
            8'h36: result = "6";  8'h3D: result = "7";  8'h3E: result = "8";
            8'h46: result = "9";
            8'h29: result = 8'h20;
            8'h5A: result = 8'h0D;
            8'h66: result = 8'h08;
            default: result = 8'h00;
        endcase
        if (letter != 8'h00) begin
            result = sh ? (letter - 8'h20) : letter;
        end
        return result;
    endfunction

    // Classify the incoming byte and build the event it would complete.
    always_comb begin
        w_is_pfx = (rx_data == C_PFX_EXT) || (rx_data == C_PFX_BRK);
        case (rx_data)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFF: w_is_noise = 1'b1;
            default:                                         w_is_noise = 1'b0;
        endcase
        w_complete = rx_valid && !w_is_pfx &&
                     !((r_state == ST_IDLE) && w_is_noise);
        w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
        w_brk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
        // ASCII uses the shift state from before this event updates it.
        if (w_brk) begin
            w_ascii = 8'h00;
        end else if (w_ext) begin
            w_ascii = (rx_data == C_ENTER) ? 8'h0D : 8'h00;
        end else begin
            w_ascii = f_make_ascii(rx_data, shift);
        end
        w_entry = {w_ext, w_brk, rx_data, w_ascii};
    end

    // FIFO handshake: pop when head is consumed, push unless full without pop.
    always_comb begin
        w_empty = (r_count == 3'd0);
        w_pop   = !w_empty && ev_ready;
        w_push  = w_complete && ((r_count != C_FIFO_FULL) || w_pop);
        w_drop  = w_complete && (r_count == C_FIFO_FULL) && !w_pop;
        w_head  = r_mem[r_rd_ptr];
    end

    // Prefix state machine; only bytes with rx_valid advance it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == C_PFX_EXT)      r_state <= ST_EXT;
                    else if (rx_data == C_PFX_BRK) r_state <= ST_BRK;
                    else                           r_state <= ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_data == C_PFX_BRK)      r_state <= ST_EXT_BRK;
                    else if (rx_data == C_PFX_EXT) r_state <= ST_EXT;
                    else                           r_state <= ST_IDLE;
                end
                ST_BRK: begin
                    if (rx_data == C_PFX_EXT)      r_state <= ST_EXT_BRK;
                    else if (rx_data == C_PFX_BRK) r_state <= ST_BRK;
                    else                           r_state <= ST_IDLE;
                end
                default: begin
                    if (w_is_pfx) r_state <= ST_EXT_BRK;
                    else          r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Shift flags follow non-extended 0x12/0x59, even if the event is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
        end else if (w_complete && !w_ext) begin
            if (rx_data == C_LSHIFT) r_shift_l <= !w_brk;
            if (rx_data == C_RSHIFT) r_shift_r <= !w_brk;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            if (w_push && !w_pop)      r_count <= r_count + 3'd1;
            else if (w_pop && !w_push) r_count <= r_count - 3'd1;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // FIFO storage; contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    // Head-of-queue outputs, forced to zero while the queue is empty.
    always_comb begin
        ev_valid = !w_empty;
        ev_ext   = w_empty ? 1'b0  : w_head[17];
        ev_break = w_empty ? 1'b0  : w_head[16];
        ev_code  = w_empty ? 8'h00 : w_head[15:8];
        ev_ascii = w_empty ? 8'h00 : w_head[7:0];
        shift    = r_shift_l || r_shift_r;
        ovf      = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_decoder
// Description : Directed self-checking bench for ps2_scancode_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [7:0] ev_ascii;
    logic       shift;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    ps2_scancode_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_break (ev_break),
        .ev_ascii (ev_ascii),
        .shift    (shift),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns at the falling edge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Check the head entry, then pop it.
    task automatic pop_expect(input string tag, input logic [7:0] code,
                              input logic ext, input logic brk,
                              input logic [7:0] ascii);
        check({tag, ".valid"}, ev_valid, 1'b1);
        check({tag, ".code"},  ev_code,  code);
        check({tag, ".ext"},   ev_ext,   ext);
        check({tag, ".brk"},   ev_break, brk);
        check({tag, ".ascii"}, ev_ascii, ascii);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; ev_ready = 1'b0;
        #12;
        check("rst.valid", ev_valid, 1'b0);
        check("rst.code",  ev_code,  8'h00);
        check("rst.shift", shift,    1'b0);
        check("rst.ovf",   ovf,      1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Make then break of 'a' with the consumer always ready.
        ev_ready = 1'b1;
        check("a.pre_valid", ev_valid, 1'b0);
        send(8'h1C);
        check("a.valid", ev_valid, 1'b1);
        check("a.code",  ev_code,  8'h1C);
        check("a.brk",   ev_break, 1'b0);
        check("a.ascii", ev_ascii, 8'h61);
        send(8'hF0);
        check("abrk.pfx_valid", ev_valid, 1'b0);
        send(8'h1C);
        check("abrk.valid", ev_valid, 1'b1);
        check("abrk.code",  ev_code,  8'h1C);
        check("abrk.brk",   ev_break, 1'b1);
        check("abrk.ascii", ev_ascii, 8'h00);
        @(negedge clk);
        check("abrk.drained", ev_valid, 1'b0);
        ev_ready = 1'b0;

        // Shift handling; ascii uses the shift value before the event.
        send(8'h12);
        check("sh.on", shift, 1'b1);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        check("sh.off", shift, 1'b0);
        send(8'h1C);
        pop_expect("sh.e0", 8'h12, 1'b0, 1'b0, 8'h00);
        pop_expect("sh.e1", 8'h1C, 1'b0, 1'b0, 8'h41);
        pop_expect("sh.e2", 8'h12, 1'b0, 1'b1, 8'h00);
        pop_expect("sh.e3", 8'h1C, 1'b0, 1'b0, 8'h61);
        check("sh.empty", ev_valid, 1'b0);

        // Extended keys: keypad enter make and E0 F0 75 break.
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'hF0); send(8'h75);
        pop_expect("ext.e0", 8'h5A, 1'b1, 1'b0, 8'h0D);
        pop_expect("ext.e1", 8'h75, 1'b1, 1'b1, 8'h00);

        // Fill to 4, push while popping at full, then overflow.
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        check("full.ovf0", ovf, 1'b0);
        @(negedge clk);
        rx_data = 8'h2E; rx_valid = 1'b1; ev_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; ev_ready = 1'b0;
        check("full.pushpop_ovf", ovf, 1'b0);
        send(8'h45);
        check("full.ovf1", ovf, 1'b1);
        pop_expect("full.e0", 8'h1E, 1'b0, 1'b0, 8'h32);
        pop_expect("full.e1", 8'h26, 1'b0, 1'b0, 8'h33);
        pop_expect("full.e2", 8'h25, 1'b0, 1'b0, 8'h34);
        pop_expect("full.e3", 8'h2E, 1'b0, 1'b0, 8'h35);
        check("full.empty",      ev_valid, 1'b0);
        check("full.empty_code", ev_code,  8'h00);
        check("full.ovf_sticky", ovf,      1'b1);

        // Noise bytes in IDLE, then reset mid-prefix.
        send(8'hAA); send(8'hFA);
        check("noise.valid", ev_valid, 1'b0);
        send(8'hE0);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        check("midrst.ovf", ovf, 1'b0);
        send(8'h1C);
        pop_expect("midrst.e0", 8'h1C, 1'b0, 1'b0, 8'h61);

        // Async reset with 3 queued, shift held and overflow set.
        send(8'h12); send(8'h1C); send(8'h1D); send(8'h15); send(8'h24);
        check("async.ovf_pre", ovf, 1'b1);
        pop_expect("async.e0", 8'h12, 1'b0, 1'b0, 8'h00);
        check("async.shift_pre", shift, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async.valid", ev_valid, 1'b0);
        check("async.shift", shift,    1'b0);
        check("async.ovf",   ovf,      1'b0);
        check("async.code",  ev_code,  8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
